// File: rtl/fir_mac_pkg.sv
// Shared types and helpers for the time-shared FIR MAC scheduler.
package fir_mac_pkg;

    // Widths for the default 4-channel, 32-tap configuration.
    localparam int NCH_W = 2;
    localparam int TAP_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MAC,
        DRAIN,
        OUT
    } sched_state_t;

    // Clamp a signed value into the range of an ow-bit signed word.
    function automatic logic signed [63:0] sat_ow(input logic signed [63:0] v, input int ow);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        if (v > hi)      sat_ow = hi;
        else if (v < lo) sat_ow = lo;
        else             sat_ow = v;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after 'last', wrapping.
module rr_arbiter #(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0]         req,
    input  logic [$clog2(NCH)-1:0] last,
    output logic [NCH-1:0]         gnt,
    output logic [$clog2(NCH)-1:0] idx,
    output logic                   any
);
    // Scan from last+1 around to last; the first hit wins.
    always_comb begin
        int j;
        gnt = '0;
        idx = last;
        any = 1'b0;
        j   = 0;
        for (int i = 1; i <= NCH; i++) begin
            j = (int'(last) + i) % NCH;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = ($clog2(NCH))'(j);
            end
        end
    end
endmodule

// File: rtl/fir_mac_sched.sv
// Time-shared FIR MAC scheduler: one MAC serves NCH decimated channels.
// Optional build macro FIR_SYM_FOLD_EN: symmetric-coefficient folding,
// halving the MAC walk with a pre-adder.
module fir_mac_sched
    import fir_mac_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int NTAPS = 32,
    parameter int DW    = 18,
    parameter int CW    = 16,
    parameter int ACCW  = 40,
    parameter int OW    = 16,
    parameter int SHIFT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH-1:0]           in_valid,
    input  logic [NCH*DW-1:0]        in_data,
    output logic [$clog2(NTAPS)-1:0] coef_addr,
    input  logic [CW-1:0]            coef_data,
    output logic                     out_valid,
    output logic [$clog2(NCH)-1:0]   out_ch,
    output logic [OW-1:0]            out_data,
    output logic                     busy,
    output logic [NCH-1:0]           overrun,
    input  logic                     overrun_clr
);
    localparam int CHW = $clog2(NCH);
    localparam int TW  = $clog2(NTAPS);
`ifdef FIR_SYM_FOLD_EN
    localparam int SW  = DW + 1;        // pre-added sample pair
    localparam int NK  = NTAPS / 2;
`else
    localparam int SW  = DW;
    localparam int NK  = NTAPS;
`endif
    localparam int PW  = SW + CW;

    sched_state_t                      state_q, state_d;
    logic [CHW-1:0]                    ch_q, ch_d, rr_q, rr_d;
    logic [NCH-1:0]                    ch_oh_q, ch_oh_d;
    logic [TW-1:0]                     k_q, k_d;
    logic [NCH-1:0][DW-1:0]            hold_q, hold_d;
    logic [NCH-1:0]                    pend_q, pend_d, ovr_q, ovr_d, pend_clr;
    logic [NCH-1:0][TW-1:0]            wptr_q, wptr_d;
    logic [NCH-1:0][NTAPS-1:0][DW-1:0] line_q, line_d;
    logic signed [SW-1:0]              samp_q, samp_d;
    logic signed [PW-1:0]              prod_q, prod_d;
    logic signed [ACCW-1:0]            acc_q, acc_d;
    logic [1:0]                        vld_pipe_q, vld_pipe_d;
    logic                              out_valid_q, out_valid_d;
    logic [CHW-1:0]                    out_ch_q, out_ch_d;
    logic [OW-1:0]                     out_data_q, out_data_d;
    logic [NCH-1:0]                    arb_gnt;
    logic [CHW-1:0]                    arb_idx;
    logic                              arb_any;
    logic [TW-1:0]                     rd_a_idx;
    logic signed [DW-1:0]              rd_a;
`ifdef FIR_SYM_FOLD_EN
    logic [TW-1:0]                     rd_b_idx;
    logic signed [DW-1:0]              rd_b;
`endif

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req  (pend_q),
        .last (rr_q),
        .gnt  (arb_gnt),
        .idx  (arb_idx),
        .any  (arb_any)
    );

    // MAC pipeline: tap read -> sample reg (aligned with ROM data) -> product reg -> accumulate.
    always_comb begin
        rd_a_idx = wptr_q[ch_q] - k_q;
        rd_a     = line_q[ch_q][rd_a_idx];
`ifdef FIR_SYM_FOLD_EN
        // Mirror tap NTAPS-1-k sits at wptr+k+1.
        rd_b_idx = wptr_q[ch_q] + k_q + 1'b1;
        rd_b     = line_q[ch_q][rd_b_idx];
        samp_d   = SW'(rd_a) + SW'(rd_b);
`else
        samp_d   = rd_a;
`endif
        prod_d     = PW'(samp_q) * PW'($signed(coef_data));
        vld_pipe_d = {vld_pipe_q[0], state_q == MAC};
    end

    // Scheduler FSM, capture of incoming samples and result formatting.
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        ch_oh_d     = ch_oh_q;
        rr_d        = rr_q;
        k_d         = k_q;
        hold_d      = hold_q;
        wptr_d      = wptr_q;
        line_d      = line_q;
        acc_d       = acc_q;
        out_valid_d = 1'b0;
        out_ch_d    = out_ch_q;
        out_data_d  = out_data_q;
        pend_clr    = '0;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    ch_d    = arb_idx;
                    ch_oh_d = arb_gnt;
                    rr_d    = arb_idx;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                line_d[ch_q][wptr_q[ch_q]] = hold_q[ch_q];
                pend_clr = ch_oh_q;
                k_d      = '0;
                acc_d    = '0;
                state_d  = MAC;
            end
            MAC: begin
                // k parks on the last tap so coef_addr holds outside MAC.
                if (k_q == TW'(NK - 1)) state_d = DRAIN;
                else                    k_d     = k_q + 1'b1;
            end
            DRAIN: begin
                // Last sample has left stage 0: the final product accumulates this cycle.
                if (!vld_pipe_q[0]) state_d = OUT;
            end
            OUT: begin
                out_valid_d  = 1'b1;
                out_ch_d     = ch_q;
                out_data_d   = OW'(sat_ow(64'(acc_q >>> SHIFT), OW));
                wptr_d[ch_q] = wptr_q[ch_q] + 1'b1;
                state_d      = IDLE;
                // Back-to-back service: arbitrate here so results come every NK+4 cycles.
                if (arb_any) begin
                    ch_d    = arb_idx;
                    ch_oh_d = arb_gnt;
                    rr_d    = arb_idx;
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
        if (vld_pipe_q[1]) acc_d = acc_q + ACCW'(prod_q);
        // A new strobe beats a same-cycle LOAD clear and then is not an overrun.
        for (int c = 0; c < NCH; c++) begin
            if (in_valid[c]) hold_d[c] = in_data[c*DW +: DW];
            pend_d[c] = (pend_q[c] & ~pend_clr[c]) | in_valid[c];
            ovr_d[c]  = (ovr_q[c] & ~overrun_clr) | (in_valid[c] & pend_q[c] & ~pend_clr[c]);
        end
    end

    // State registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            ch_oh_q     <= '0;
            rr_q        <= '0;
            k_q         <= '0;
            hold_q      <= '0;
            pend_q      <= '0;
            ovr_q       <= '0;
            wptr_q      <= '0;
            line_q      <= '0;
            samp_q      <= '0;
            prod_q      <= '0;
            acc_q       <= '0;
            vld_pipe_q  <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            ch_oh_q     <= ch_oh_d;
            rr_q        <= rr_d;
            k_q         <= k_d;
            hold_q      <= hold_d;
            pend_q      <= pend_d;
            ovr_q       <= ovr_d;
            wptr_q      <= wptr_d;
            line_q      <= line_d;
            samp_q      <= samp_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            vld_pipe_q  <= vld_pipe_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_data_q  <= out_data_d;
        end
    end

    assign coef_addr = k_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_fir_mac_sched.sv
// Directed bench for fir_mac_sched: impulse, saturation, round-robin, overrun, mid-MAC reset.
module tb_fir_mac_sched;
    localparam int NCH   = 4;
    localparam int NTAPS = 32;
    localparam int DW    = 18;
    localparam int CW    = 16;
    localparam int OW    = 16;
`ifdef FIR_SYM_FOLD_EN
    localparam int LAT   = NTAPS / 2 + 4;
`else
    localparam int LAT   = NTAPS + 4;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    in_valid;
    logic [NCH*DW-1:0] in_data;
    logic [4:0]        coef_addr;
    logic [CW-1:0]     coef_data;
    logic              out_valid;
    logic [1:0]        out_ch;
    logic [OW-1:0]     out_data;
    logic              busy;
    logic [NCH-1:0]    overrun;
    logic              overrun_clr;

    fir_mac_sched #(.NCH(NCH), .NTAPS(NTAPS), .DW(DW), .CW(CW), .ACCW(40), .OW(OW), .SHIFT(0)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .coef_addr   (coef_addr),
        .coef_data   (coef_data),
        .out_valid   (out_valid),
        .out_ch      (out_ch),
        .out_data    (out_data),
        .busy        (busy),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    // Coefficient ROM model with one cycle of read latency.
    logic [CW-1:0] rom [NTAPS];
    always @(posedge clk) coef_data <= rom[coef_addr];

    typedef struct {
        int ch;
        int data;
        int exp;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   n;
    int   busy_cnt, nout;
    int   out_at[4];
    int   out_chs[4];
    int   out_dat[4];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic rom_ramp();
        for (int i = 0; i < NTAPS; i++) rom[i] = CW'(i + 1);
    endtask

    task automatic rom_fill(input int v, input int v0);
        for (int i = 0; i < NTAPS; i++) rom[i] = CW'(v);
        rom[0] = CW'(v0);
    endtask

    // Wait (bounded) for the FSM to leave IDLE.
    task automatic wait_busy(input string tag);
        n = 0;
        while (!busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!busy) begin
            checks++;
            errors++;
            $display("FAIL %s: busy never rose", tag);
        end
    endtask

    // Advance at least one cycle, then wait (bounded) for out_valid.
    task automatic wait_out();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 200);
    endtask

    // One sample on one channel; checks latency from selection, channel and value.
    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        in_valid = '0;
        in_valid[v.ch] = 1'b1;
        in_data[v.ch*DW +: DW] = DW'(v.data);
        @(negedge clk);
        in_valid = '0;
        wait_busy(tag);
        wait_out();
        chk({tag, " latency"}, n, LAT);
        chk({tag, " out_ch"}, out_ch, v.ch);
        chk({tag, " out_data"}, $signed(out_data), v.exp);
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("%s[%0d]", tag, i));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        in_valid = '0;
        in_data = '0;
        overrun_clr = 1'b0;
        rom_ramp();
        repeat (3) @(negedge clk);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_data", out_data, 0);
        chk("reset out_ch", out_ch, 0);
        chk("reset busy", busy, 0);
        chk("reset overrun", overrun, 0);
        chk("reset coef_addr", coef_addr, 0);
        rst = 1'b1;

        // Impulse on ch0 with coef[k]=k+1: response is 1..32 then zeros.
        vecs.delete();
        for (int i = 0; i < NTAPS + 2; i++) vecs.push_back('{0, (i == 0) ? 1 : 0, (i < NTAPS) ? i + 1 : 0});
        run_table("imp0");

        // Saturation on ch3: window of j negatives and 32-j positives turns negative at j=16.
        rom_fill(32767, 32767);
        vecs.delete();
        for (int i = 0; i < NTAPS; i++) vecs.push_back('{3, 131071, 32767});
        for (int j = 1; j <= NTAPS; j++) vecs.push_back('{3, -131072, (j < 16) ? 32767 : -32768});
        run_table("sat");

        // Fresh state, then serve ch3 once so the next round starts at ch0.
        pulse_reset();
        rom_fill(1, 1);
        vecs.delete();
        vecs.push_back('{3, 0, 0});
        run_table("prime");

        // Round-robin: all channels strobe together.
        @(negedge clk);
        in_valid = '1;
        for (int c = 0; c < NCH; c++) in_data[c*DW +: DW] = DW'(100);
        @(negedge clk);
        in_valid = '0;
        busy_cnt = 0;
        nout = 0;
        for (int i = 1; i <= 170; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (out_valid && nout < 4) begin
                out_at[nout]  = i;
                out_chs[nout] = int'(out_ch);
                out_dat[nout] = int'($signed(out_data));
                nout++;
            end
        end
        chk("rr result count", nout, 4);
        chk("rr busy cycles", busy_cnt, 4 * LAT);
        for (int j = 0; j < nout; j++) begin
            chk($sformatf("rr[%0d] ch", j), out_chs[j], j);
            chk($sformatf("rr[%0d] data", j), out_dat[j], 100);
            chk($sformatf("rr[%0d] time", j), out_at[j], LAT + 1 + j * LAT);
        end

        // Overrun: two ch2 strobes while ch0 is in service; the later sample wins.
        rom_fill(0, 1);
        @(negedge clk);
        in_valid = 4'b0001;
        in_data[0*DW +: DW] = DW'(50);
        @(negedge clk);
        in_valid = '0;
        wait_busy("ovr start");
        in_valid = 4'b0100;
        in_data[2*DW +: DW] = DW'(5);
        @(negedge clk);
        in_data[2*DW +: DW] = DW'(7);
        @(negedge clk);
        in_valid = '0;
        @(negedge clk);
        chk("ovr flag set", overrun, 4'b0100);
        wait_out();
        chk("ovr ch0 out_ch", out_ch, 0);
        chk("ovr ch0 out_data", $signed(out_data), 50);
        wait_out();
        chk("ovr ch2 out_ch", out_ch, 2);
        chk("ovr ch2 out_data", $signed(out_data), 7);
        chk("ovr flag sticky", overrun, 4'b0100);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        chk("ovr flag cleared", overrun, 0);

        // Reset in MAC cycle 10, then a clean impulse on ch1.
        rom_ramp();
        @(negedge clk);
        in_valid = 4'b0001;
        in_data[0*DW +: DW] = DW'(1000);
        @(negedge clk);
        in_valid = '0;
        wait_busy("mid start");
        repeat (11) @(negedge clk);
        chk("mid coef_addr before", coef_addr, 10);
        #2 rst = 1'b0;
        #1;
        chk("mid out_data", out_data, 0);
        chk("mid out_valid", out_valid, 0);
        chk("mid busy", busy, 0);
        chk("mid coef_addr", coef_addr, 0);
        chk("mid overrun", overrun, 0);
        @(negedge clk);
        rst = 1'b1;
        vecs.delete();
        for (int i = 0; i < NTAPS + 2; i++) vecs.push_back('{1, (i == 0) ? 1 : 0, (i < NTAPS) ? i + 1 : 0});
        run_table("imp1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
